regfile_sb: RTL and testbench

- Parametrised multi-entry register file: DEPTH entries of WIDTH bits, one write port and two read ports.
- Read paths are combinational with write-through bypass; register 0 can be hardwired to zero.
- A per-register busy scoreboard tracks pending writes, so multicycle units (mult/div) can reserve a destination register and the pipeline can stall on hazards.
- Sits between decode (reads, reservations) and writeback (writes, busy release).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_sb_busy_scoreboard.sv | 54 +++++
 rtl/regfile_sb.sv | 87 ++++++++
 tb/tb_regfile_sb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Imported by the top level and by the busy scoreboard.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int ZERO_IDX  = 0;

  // Index width for a given depth; never less than one bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_sb_busy_scoreboard.sv
// Per-register pending-write tracker.
// Reserve beats release on the same register; a reserve of an already-busy register pulses err.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reserve,
  input  logic [AW-1:0]    reserve_idx,
  input  logic             release_en,
  input  logic [AW-1:0]    release_idx,
  output logic [DEPTH-1:0] busy_vector,
  output logic             err_double_reserve
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             err_reg;
  logic             err_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if ((ZERO_REG != 0) && (gi == ZERO_IDX)) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        assign busy_next[gi] = (reserve && (reserve_idx == AW'(gi)))    ? 1'b1 :
                               (release_en && (release_idx == AW'(gi))) ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // Uses the busy state from before the edge, so a same-cycle release does not mask it.
  assign err_next = reserve && busy_reg[reserve_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  assign busy_vector        = busy_reg;
  assign err_double_reserve = err_reg;

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two bypassed combinational read ports
// and a busy scoreboard for multicycle destinations.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [AW-1:0]    ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [AW-1:0]    ctrl_readRegA,
  input  logic [AW-1:0]    ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic             busy_A,
  output logic             busy_B,
  input  logic             ctrl_reserve,
  input  logic [AW-1:0]    ctrl_reserveReg,
  output logic             err_double_reserve,
  output logic [DEPTH-1:0] busy_vector
);

  localparam bit          ZERO_EN = (ZERO_REG != 0);
  localparam logic [AW-1:0] ZERO_AW = AW'(ZERO_IDX);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             wr_ok;

  assign wr_ok = ctrl_writeEnable && !(ZERO_EN && (ctrl_writeReg == ZERO_AW));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_reg[ctrl_writeReg] <= data_writeReg;
    end
  end

  busy_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock              (clock),
    .reset              (reset),
    .reserve            (ctrl_reserve),
    .reserve_idx        (ctrl_reserveReg),
    .release_en         (ctrl_writeEnable),
    .release_idx        (ctrl_writeReg),
    .busy_vector        (busy_vector),
    .err_double_reserve (err_double_reserve)
  );

  logic [AW-1:0]    rd_idx  [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign rd_idx[0] = ctrl_readRegA;
  assign rd_idx[1] = ctrl_readRegB;

  // Outputs are forced quiet while reset is held so a pending bypass cannot leak out.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic hit;
      logic is_zero;
      assign hit     = ctrl_writeEnable && (ctrl_writeReg == rd_idx[gi]);
      assign is_zero = ZERO_EN && (rd_idx[gi] == ZERO_AW);
      assign rd_data[gi] = (!reset || is_zero) ? '0 :
                           hit                 ? data_writeReg :
                           mem_reg[rd_idx[gi]];
      assign rd_busy[gi] = reset && busy_vector[rd_idx[gi]] && !hit;
    end
  endgenerate

  assign data_readRegA = rd_data[0];
  assign data_readRegB = rd_data[1];
  assign busy_A        = rd_busy[0];
  assign busy_B        = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a behavioural array model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clock;
  logic             reset;
  logic             ctrl_writeEnable;
  logic [AW-1:0]    ctrl_writeReg;
  logic [WIDTH-1:0] data_writeReg;
  logic [AW-1:0]    ctrl_readRegA;
  logic [AW-1:0]    ctrl_readRegB;
  logic [WIDTH-1:0] data_readRegA;
  logic [WIDTH-1:0] data_readRegB;
  logic             busy_A;
  logic             busy_B;
  logic             ctrl_reserve;
  logic [AW-1:0]    ctrl_reserveReg;
  logic             err_double_reserve;
  logic [DEPTH-1:0] busy_vector;

  int n_compared = 0;
  int n_mismatched = 0;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clock              (clock),
    .reset              (reset),
    .ctrl_writeEnable   (ctrl_writeEnable),
    .ctrl_writeReg      (ctrl_writeReg),
    .data_writeReg      (data_writeReg),
    .ctrl_readRegA      (ctrl_readRegA),
    .ctrl_readRegB      (ctrl_readRegB),
    .data_readRegA      (data_readRegA),
    .data_readRegB      (data_readRegB),
    .busy_A             (busy_A),
    .busy_B             (busy_B),
    .ctrl_reserve       (ctrl_reserve),
    .ctrl_reserveReg    (ctrl_reserveReg),
    .err_double_reserve (err_double_reserve),
    .busy_vector        (busy_vector)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: plain arrays updated by the architectural rules.
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];
  bit               m_err;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  initial model_clear();
  always @(negedge reset) model_clear();

  always @(posedge clock) begin
    if (reset) begin
      bit e;
      e = ctrl_reserve && m_busy[ctrl_reserveReg];
      if (ctrl_writeEnable) begin
        if (ctrl_writeReg != 0) m_mem[ctrl_writeReg] = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_reserve && ctrl_reserveReg != 0) m_busy[ctrl_reserveReg] = 1'b1;
      m_err = e;
    end
  end

  function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] idx);
    if (!reset || idx == 0) return '0;
    if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] idx);
    if (!reset) return 1'b0;
    return m_busy[idx] && !(ctrl_writeEnable && ctrl_writeReg == idx);
  endfunction

  function automatic logic [DEPTH-1:0] exp_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    check("model_dataA", data_readRegA, exp_data(ctrl_readRegA));
    check("model_dataB", data_readRegB, exp_data(ctrl_readRegB));
    check("model_busyA", {31'b0, busy_A}, {31'b0, exp_busy(ctrl_readRegA)});
    check("model_busyB", {31'b0, busy_B}, {31'b0, exp_busy(ctrl_readRegB)});
    check("model_busyvec", busy_vector, exp_vec());
    check("model_err", {31'b0, err_double_reserve}, {31'b0, m_err});
  end

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    ctrl_reserve     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic drive_write(input logic [AW-1:0] r, input logic [WIDTH-1:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
  endtask

  task automatic drive_reserve(input logic [AW-1:0] r);
    ctrl_reserve    = 1'b1;
    ctrl_reserveReg = r;
  endtask

  initial begin
    reset = 1'b0;
    ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_reserve = 1'b0; ctrl_reserveReg = '0;
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd31;
    repeat (3) tick();

    // 1: reset state after release
    reset = 1'b1;
    #2;
    check("rst_dataA", data_readRegA, 32'h0);
    check("rst_dataB", data_readRegB, 32'h0);
    check("rst_busyA", {31'b0, busy_A}, 32'h0);
    check("rst_vec", busy_vector, 32'h0);
    check("rst_err", {31'b0, err_double_reserve}, 32'h0);
    tick();

    // 2: write-through bypass, then stored value
    drive_write(5'd7, 32'hDEADBEEF);
    ctrl_readRegA = 5'd7;
    #2 check("bypass_A7", data_readRegA, 32'hDEADBEEF);
    tick();
    #2 check("stored_A7", data_readRegA, 32'hDEADBEEF);

    // 3: register 0 ignores writes and reserves
    drive_write(5'd0, 32'hFFFFFFFF);
    drive_reserve(5'd0);
    ctrl_readRegA = 5'd0;
    #2 check("zero_dataA", data_readRegA, 32'h0);
    check("zero_busyA", {31'b0, busy_A}, 32'h0);
    tick();
    #2 check("zero_vec0", {31'b0, busy_vector[0]}, 32'h0);
    check("zero_err", {31'b0, err_double_reserve}, 32'h0);

    // 4: reserve reg 3, release four cycles later
    drive_reserve(5'd3);
    ctrl_readRegA = 5'd3;
    #2 check("res3_notyet", {31'b0, busy_A}, 32'h0);
    tick();
    #2 check("res3_busy", {31'b0, busy_A}, 32'h1);
    tick();
    tick();
    tick();
    drive_write(5'd3, 32'h12);
    #2 check("wb3_busyA", {31'b0, busy_A}, 32'h0);
    check("wb3_dataA", data_readRegA, 32'h12);
    tick();
    #2 check("wb3_vec", {31'b0, busy_vector[3]}, 32'h0);
    check("wb3_stored", data_readRegA, 32'h12);

    // 5: double reserve of reg 9, then reserve+write in the same cycle
    drive_reserve(5'd9);
    tick();
    drive_reserve(5'd9);
    #2 check("dbl_err_pre", {31'b0, err_double_reserve}, 32'h0);
    tick();
    #2 check("dbl_err_pulse", {31'b0, err_double_reserve}, 32'h1);
    tick();
    #2 check("dbl_err_clear", {31'b0, err_double_reserve}, 32'h0);
    drive_reserve(5'd9);
    drive_write(5'd9, 32'h99);
    ctrl_readRegA = 5'd9;
    tick();
    #2 check("rw9_vec", {31'b0, busy_vector[9]}, 32'h1);
    check("rw9_data", data_readRegA, 32'h99);
    check("rw9_busyA", {31'b0, busy_A}, 32'h1);
    check("rw9_err", {31'b0, err_double_reserve}, 32'h1);
    drive_write(5'd9, 32'h55);
    tick();

    // 6: asynchronous reset mid-cycle with reg 4 busy
    drive_write(5'd4, 32'hAA);
    drive_reserve(5'd4);
    tick();
    ctrl_readRegA = 5'd4;
    ctrl_readRegB = 5'd4;
    #2 check("pre_rst_vec4", {31'b0, busy_vector[4]}, 32'h1);
    check("pre_rst_data4", data_readRegA, 32'hAA);
    reset = 1'b0;
    #1 check("async_vec", busy_vector, 32'h0);
    check("async_dataB", data_readRegB, 32'h0);
    tick();
    reset = 1'b1;
    #2 check("post_rst_data4", data_readRegA, 32'h0);
    check("post_rst_busy4", {31'b0, busy_A}, 32'h0);
    tick();
    #2 check("post_rst_vec", busy_vector, 32'h0);

    // Mixed traffic checked by the model every cycle.
    for (int c = 0; c < 60; c++) begin
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      ctrl_writeReg    = 5'($urandom_range(0, 7));
      data_writeReg    = $urandom;
      ctrl_reserve     = 1'($urandom_range(0, 1));
      ctrl_reserveReg  = 5'($urandom_range(0, 7));
      ctrl_readRegA    = 5'($urandom_range(0, 7));
      ctrl_readRegB    = 5'($urandom_range(0, 7));
      @(posedge clock);
      #1;
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
